// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package seq_tx_pkg;

   // FSM encoding shared by the transmitter and anything decoding its state.
   typedef enum logic [1:0] {
      STATE_IDLE = 2'd0,
      STATE_SEND = 2'd1,
      STATE_GAP  = 2'd2
   } tx_state_e;

   // Width of a field able to hold 0..max_len inclusive.
   function automatic int calc_len_w(input int max_len);
      return (max_len < 1) ? 1 : $clog2(max_len + 1);
   endfunction

   // Width of a bit index addressing 0..max_len-1.
   function automatic int calc_idx_w(input int max_len);
      return (max_len < 2) ? 1 : $clog2(max_len);
   endfunction

   // Requested lengths beyond the pattern register are silently capped.
   function automatic int clamp_len(input int len, input int max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Load handshake and serial output stream of the pattern transmitter.
// Latency: none (signal bundle only).
// Backpressure: load_ready gates load_valid; the serial side has none.
interface seq_pattern_tx_if
   import seq_tx_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = calc_len_w(MAX_LEN),
   parameter int REP_W   = 4
) ();

   logic               load_valid;
   logic               load_ready;
   logic [MAX_LEN-1:0] load_pattern;
   logic [LEN_W-1:0]   load_len;
   logic [REP_W-1:0]   load_reps;
   logic               dout;
   logic               dout_valid;
   logic               frame_start;

   // Upstream side: issues loads and listens to the serial stream.
   modport master (
      output load_valid,
      output load_pattern,
      output load_len,
      output load_reps,
      input  load_ready,
      input  dout,
      input  dout_valid,
      input  frame_start
   );

   // Transmitter side.
   modport slave (
      input  load_valid,
      input  load_pattern,
      input  load_len,
      input  load_reps,
      output load_ready,
      output dout,
      output dout_valid,
      output frame_start
   );

endinterface

// File: rtl/seq_tx_shifter.sv
// Pattern register with a down-counting bit index that wraps for repeated frames.
// Latency: bit_out is the bit for the next cycle, combinational from load/advance.
// Backpressure: none; the index moves only when advance is asserted.
module seq_tx_shifter
   import seq_tx_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               advance,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   eff_len,
   output logic               bit_out,
   output logic               last_bit
);

   localparam int IDX_W = calc_idx_w(MAX_LEN);

   logic [MAX_LEN-1:0] pattern_q;
   logic [IDX_W-1:0]   top_q;
   logic [IDX_W-1:0]   idx_q;
   logic [IDX_W-1:0]   idx_nxt;
   logic [IDX_W-1:0]   load_top;

   // Index of the first (MSB) bit of a frame; eff_len is never 0 when load is used.
   assign load_top = IDX_W'(eff_len - LEN_W'(1));

   // Next index: restart on load, step down on advance, wrap after bit 0 so the
   // following frame (back-to-back or after a gap) starts at the MSB again.
   always_comb begin
      idx_nxt = idx_q;
      if (load) begin
         idx_nxt = load_top;
      end else if (advance) begin
         idx_nxt = (idx_q == '0) ? top_q : idx_q - IDX_W'(1);
      end
   end

   // Look-ahead bit so the owner can register it alongside its own state change.
   always_comb begin
      bit_out = load ? pattern[load_top] : pattern_q[idx_nxt];
   end

   assign last_bit = (idx_q == '0);

   // Pattern, frame top index and running index.
   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q <= '0;
         top_q     <= '0;
         idx_q     <= '0;
      end else begin
         if (load) begin
            pattern_q <= pattern;
            top_q     <= load_top;
         end
         idx_q <= idx_nxt;
      end
   end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial MSB-first pattern transmitter with repeat count and inter-frame gap.
// Latency: first bit one cycle after load acceptance; done one cycle after the last bit.
// Backpressure: load_ready only in IDLE; loads while busy are dropped, not queued.
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = calc_len_w(MAX_LEN),
   parameter int REP_W   = 4,
   parameter int GAP     = 1
) (
   input  logic            clk,
   input  logic            reset,
   seq_pattern_tx_if.slave bus,
   input  logic            abort,
   output logic            busy,
   output logic            done
);

   localparam int FR_W  = REP_W + 1;
   localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   localparam logic [1:0] ST_IDLE = STATE_IDLE;
   localparam logic [1:0] ST_SEND = STATE_SEND;
   localparam logic [1:0] ST_GAP  = STATE_GAP;

   logic [1:0]       state_q;
   logic [1:0]       state_nxt;
   logic [FR_W-1:0]  frames_q;
   logic [FR_W-1:0]  frames_nxt;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_nxt;
   logic [LEN_W-1:0] eff_len;
   logic             accept;
   logic             done_nxt;
   logic             send_nxt;
   logic             sh_load;
   logic             sh_advance;
   logic             sh_bit;
   logic             sh_last;

   assign eff_len  = LEN_W'(clamp_len(int'(bus.load_len), MAX_LEN));
   assign accept   = bus.load_valid & bus.load_ready;
   assign send_nxt = (state_nxt == ST_SEND);

   seq_tx_shifter #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_shifter (
      .clk      (clk),
      .reset    (reset),
      .load     (sh_load),
      .advance  (sh_advance),
      .pattern  (bus.load_pattern),
      .eff_len  (eff_len),
      .bit_out  (sh_bit),
      .last_bit (sh_last)
   );

   // Next-state logic: frame sequencing, gap timing, abort and completion.
   always_comb begin
      state_nxt  = state_q;
      frames_nxt = frames_q;
      gap_nxt    = gap_q;
      done_nxt   = 1'b0;
      sh_load    = 1'b0;
      sh_advance = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               // One extra bit so all-ones reps counts 2^REP_W frames without wrap.
               frames_nxt = FR_W'(bus.load_reps) + FR_W'(1);
               if (eff_len == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt = ST_SEND;
                  sh_load   = 1'b1;
               end
            end
         end
         ST_SEND: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else begin
               sh_advance = 1'b1;
               if (sh_last) begin
                  if (frames_q == FR_W'(1)) begin
                     state_nxt = ST_IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     frames_nxt = frames_q - FR_W'(1);
                     if (GAP > 0) begin
                        state_nxt = ST_GAP;
                        gap_nxt   = GAP_RELOAD;
                     end
                  end
               end
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (gap_q == '0) begin
               state_nxt = ST_SEND;
            end else begin
               gap_nxt = gap_q - GAP_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM state, remaining-frame and gap counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         frames_q <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_nxt;
         frames_q <= frames_nxt;
         gap_q    <= gap_nxt;
      end
   end

   // Output registers, all derived from the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.dout        <= 1'b0;
         bus.dout_valid  <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.load_ready  <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         bus.dout        <= send_nxt & sh_bit;
         bus.dout_valid  <= send_nxt;
         // A frame starts when entering SEND, or when wrapping past bit 0 inside SEND.
         bus.frame_start <= send_nxt & ((state_q != ST_SEND) | sh_last);
         bus.load_ready  <= (state_nxt == ST_IDLE);
         busy            <= (state_nxt != ST_IDLE);
         done            <= done_nxt;
      end
   end

endmodule
